// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue controller.
// Holds the sequencer state encoding, the FPU op-number range and the legality check.
// No logic of its own; imported by the controller.
package fpu_issue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;

    // FPU op numbers occupy the contiguous range ABS.S .. SQRT.S.
    localparam logic [5:0] INST_ABS_S  = 6'd54;
    localparam logic [5:0] INST_SQRT_S = 6'd63;

    function automatic logic inst_is_legal(input logic [5:0] inst_num);
        return (inst_num >= INST_ABS_S) && (inst_num <= INST_SQRT_S);
    endfunction

endpackage

// File: rtl/fpu_issue_watchdog.sv
// Loadable down-counter with a combinational expiry flag (count == 0).
// Latency: load/decrement take effect on the next clock; expiry reflects the current count.
// No backpressure: a decrement at zero holds the counter at zero.
module fpu_issue_watchdog #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expired
);

    logic [W-1:0] count_d, count_q;

    // Next count: a load overrides a decrement; saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/fpu_issue_controller.sv
// Issue sequencer for the FPU ALU element: accept op, pulse element reset, wait completion, write back.
// Latency: RESET_CYCLES+2+element latency cycles from accept to wb_valid; illegal ops reach wb_valid in 1 cycle.
// Backpressure: one op in flight; in_ready low outside IDLE, wb_* held until wb_ready. Macro FPU_ISSUE_TIMEOUT_EN adds a WAIT watchdog.
module fpu_issue_controller
    import fpu_issue_pkg::*;
#(
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_inst_num,
    input  logic [31:0] in_fs,
    input  logic [31:0] in_ft,
    input  logic [4:0]  in_fd,
    output logic        elem_reset,
    output logic [5:0]  elem_inst_num,
    output logic [31:0] elem_fs,
    output logic [31:0] elem_ft,
    input  logic        elem_completed,
    input  logic [31:0] elem_out,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_fd,
    output logic [31:0] wb_data,
    output logic        wb_illegal,
    output logic        wb_timeout
);

    // One counter serves both the reset pulse and the watchdog, so size it for the larger.
    localparam int CNT_MAX = (RESET_CYCLES > TIMEOUT_CYCLES) ? RESET_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e      state_d, state_q;
    logic        in_ready_d, in_ready_q;
    logic        elem_reset_d, elem_reset_q;
    logic [5:0]  elem_inst_num_d, elem_inst_num_q;
    logic [31:0] elem_fs_d, elem_fs_q;
    logic [31:0] elem_ft_d, elem_ft_q;
    logic        wb_valid_d, wb_valid_q;
    logic [4:0]  wb_fd_d, wb_fd_q;
    logic [31:0] wb_data_d, wb_data_q;
    logic        wb_illegal_d, wb_illegal_q;
    logic        wb_timeout_d, wb_timeout_q;

    logic          cnt_load;
    logic [CW-1:0] cnt_load_val;
    logic          cnt_dec;
    logic          cnt_zero;

`ifdef FPU_ISSUE_TIMEOUT_EN
    fpu_issue_watchdog #(.W(CW)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .expired  (cnt_zero)
    );
`else
    logic [CW-1:0] cnt_d, cnt_q;

    // Reset-pulse length counter (no watchdog in this build).
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_load) begin
            cnt_d = cnt_load_val;
        end else if (cnt_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Reset-pulse counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_zero = (cnt_q == '0);
`endif

    // Sequencer next state; outputs are derived from the next state so they leave flops.
    always_comb begin
        state_d         = state_q;
        elem_inst_num_d = elem_inst_num_q;
        elem_fs_d       = elem_fs_q;
        elem_ft_d       = elem_ft_q;
        wb_fd_d         = wb_fd_q;
        wb_data_d       = wb_data_q;
        wb_illegal_d    = wb_illegal_q;
        wb_timeout_d    = wb_timeout_q;
        cnt_load        = 1'b0;
        cnt_load_val    = '0;
        cnt_dec         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    elem_inst_num_d = in_inst_num;
                    elem_fs_d       = in_fs;
                    elem_ft_d       = in_ft;
                    wb_fd_d         = in_fd;
                    wb_data_d       = '0;
                    if (inst_is_legal(in_inst_num)) begin
                        state_d      = ST_START;
                        cnt_load     = 1'b1;
                        cnt_load_val = CW'(RESET_CYCLES - 1);
                    end else begin
                        // Illegal op never touches the element.
                        state_d      = ST_WB;
                        wb_illegal_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                if (cnt_zero) begin
                    state_d = ST_WAIT;
`ifdef FPU_ISSUE_TIMEOUT_EN
                    cnt_load     = 1'b1;
                    cnt_load_val = CW'(TIMEOUT_CYCLES - 1);
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // Completion is checked first so it wins over a same-cycle expiry.
                if (elem_completed) begin
                    state_d   = ST_WB;
                    wb_data_d = elem_out;
`ifdef FPU_ISSUE_TIMEOUT_EN
                end else if (cnt_zero) begin
                    state_d      = ST_WB;
                    wb_timeout_d = 1'b1;
                    wb_data_d    = '0;
                end else begin
                    cnt_dec = 1'b1;
`endif
                end
            end
            ST_WB: begin
                if (wb_ready) begin
                    state_d      = ST_IDLE;
                    wb_illegal_d = 1'b0;
                    wb_timeout_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d   = (state_d == ST_IDLE);
        elem_reset_d = (state_d != ST_WAIT);
        wb_valid_d   = (state_d == ST_WB);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            in_ready_q      <= 1'b1;
            elem_reset_q    <= 1'b1;
            elem_inst_num_q <= '0;
            elem_fs_q       <= '0;
            elem_ft_q       <= '0;
            wb_valid_q      <= 1'b0;
            wb_fd_q         <= '0;
            wb_data_q       <= '0;
            wb_illegal_q    <= 1'b0;
            wb_timeout_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            in_ready_q      <= in_ready_d;
            elem_reset_q    <= elem_reset_d;
            elem_inst_num_q <= elem_inst_num_d;
            elem_fs_q       <= elem_fs_d;
            elem_ft_q       <= elem_ft_d;
            wb_valid_q      <= wb_valid_d;
            wb_fd_q         <= wb_fd_d;
            wb_data_q       <= wb_data_d;
            wb_illegal_q    <= wb_illegal_d;
            wb_timeout_q    <= wb_timeout_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign elem_reset    = elem_reset_q;
    assign elem_inst_num = elem_inst_num_q;
    assign elem_fs       = elem_fs_q;
    assign elem_ft       = elem_ft_q;
    assign wb_valid      = wb_valid_q;
    assign wb_fd         = wb_fd_q;
    assign wb_data       = wb_data_q;
    assign wb_illegal    = wb_illegal_q;
    assign wb_timeout    = wb_timeout_q;

endmodule
